instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/encoder_pkg.sv | 50 +++++
 rtl/instr_pack.sv | 65 ++++++
 rtl/instr_encoder.sv | 117 +++++++++++
 tb/tb_instr_encoder.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/encoder_pkg.sv
// Shared types and constants for the RV32I program-load encoder.
// ENC_IMM_CHECK_EN adds the immediate range helper used for the sticky err flag.
package encoder_pkg;

    typedef enum logic [2:0] {
        KIND_R      = 3'd0,
        KIND_I_ALU  = 3'd1,
        KIND_LOAD   = 3'd2,
        KIND_STORE  = 3'd3,
        KIND_BRANCH = 3'd4,
        KIND_JAL    = 3'd5
    } kind_t;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_SLT = 4'b0101;
    localparam logic [3:0] ALU_SLL = 4'b0110;
    localparam logic [3:0] ALU_SRL = 4'b0111;
    localparam logic [3:0] ALU_SRA = 4'b1000;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } state_t;

`ifdef ENC_IMM_CHECK_EN
    // True when imm is representable in the immediate field of this class.
    function automatic logic imm_fits(input logic [2:0] kind, input logic [31:0] imm);
        case (kind)
            KIND_I_ALU, KIND_LOAD, KIND_STORE: return imm[31:11] == {21{imm[11]}};
            KIND_BRANCH: return (imm[31:12] == {20{imm[12]}}) && !imm[0];
            KIND_JAL:    return (imm[31:20] == {12{imm[20]}}) && !imm[0];
            default:     return 1'b1;
        endcase
    endfunction
`endif

endpackage

// File: rtl/instr_pack.sv
// Combinational packing of one encode request into an RV32I instruction word.
module instr_pack
    import encoder_pkg::*;
(
    input  logic [2:0]  kind,
    input  logic [3:0]  alu,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] word
);

    logic [2:0] funct3;
    logic       f7b5;
    logic       is_shift;
    logic       unused_imm;

    assign unused_imm = ^imm[31:21];

    // Undefined ALU codes fall back to ADD.
    always_comb begin
        funct3 = 3'b000;
        f7b5   = 1'b0;
        case (alu)
            ALU_ADD: begin funct3 = 3'b000; f7b5 = 1'b0; end
            ALU_SUB: begin funct3 = 3'b000; f7b5 = 1'b1; end
            ALU_AND: funct3 = 3'b111;
            ALU_OR:  funct3 = 3'b110;
            ALU_XOR: funct3 = 3'b100;
            ALU_SLT: funct3 = 3'b010;
            ALU_SLL: funct3 = 3'b001;
            ALU_SRL: funct3 = 3'b101;
            ALU_SRA: begin funct3 = 3'b101; f7b5 = 1'b1; end
            default: begin funct3 = 3'b000; f7b5 = 1'b0; end
        endcase
    end

    assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

    always_comb begin
        word = 32'h0;
        case (kind)
            KIND_R:
                word = {1'b0, f7b5, 5'b0, rs2, rs1, funct3, rd, OP_R};
            KIND_I_ALU:
                // Non-shift I ops drop f7b5, so SUB encodes as ADDI.
                if (is_shift)
                    word = {1'b0, f7b5, 5'b0, imm[4:0], rs1, funct3, rd, OP_I};
                else
                    word = {imm[11:0], rs1, funct3, rd, OP_I};
            KIND_LOAD:
                word = {imm[11:0], rs1, 3'b010, rd, OP_LOAD};
            KIND_STORE:
                word = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OP_STORE};
            KIND_BRANCH:
                word = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], OP_BRANCH};
            KIND_JAL:
                word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
            default:
                word = 32'h0;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Program-load session controller: encodes requests and streams words to instruction memory.
// Define ENC_IMM_CHECK_EN to enable the sticky immediate-range error flag on err.
module instr_encoder
    import encoder_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        stop,
    input  logic [31:0] base_addr,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_kind,
    input  logic [3:0]  req_alu,
    input  logic [4:0]  req_rd,
    input  logic [4:0]  req_rs1,
    input  logic [4:0]  req_rs2,
    input  logic [31:0] req_imm,
    output logic        mem_we,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [15:0] count,
    output logic        busy,
    output logic        done,
    output logic        err
);

    // Handshakes: a request transfers on a rising edge with req_valid && req_ready;
    // a memory write completes on a rising edge with mem_we && mem_ready, and the
    // output register holds mem_we/mem_addr/mem_wdata unchanged until then.

    state_t      state;
    logic [31:0] word;
    logic        accept;
    logic        wr_done;
    logic        unused_base;

    assign unused_base = ^base_addr[1:0];

    instr_pack u_pack (
        .kind (req_kind),
        .alu  (req_alu),
        .rd   (req_rd),
        .rs1  (req_rs1),
        .rs2  (req_rs2),
        .imm  (req_imm),
        .word (word)
    );

    assign req_ready = (state == ST_RUN) && (!mem_we || mem_ready);
    assign accept    = req_valid && req_ready;
    assign wr_done   = mem_we && mem_ready;
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_FIN);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
            count     <= 16'h0;
        end else begin
            if (wr_done) begin
                mem_addr <= mem_addr + 32'd4;
                if (count != 16'hFFFF)
                    count <= count + 16'd1;
            end

            if (accept) begin
                mem_we    <= 1'b1;
                mem_wdata <= word;
            end else if (mem_ready) begin
                mem_we <= 1'b0;
            end

            case (state)
                ST_IDLE:
                    if (start) begin
                        state    <= ST_RUN;
                        mem_addr <= {base_addr[31:2], 2'b00};
                        count    <= 16'h0;
                    end
                ST_RUN:
                    if (stop)
                        state <= ST_DRAIN;
                // The register is empty after this edge when nothing is pending or it drains now.
                ST_DRAIN:
                    if (!mem_we || mem_ready)
                        state <= ST_FIN;
                ST_FIN:
                    state <= ST_IDLE;
                default:
                    state <= ST_IDLE;
            endcase
        end
    end

`ifdef ENC_IMM_CHECK_EN
    logic imm_bad;

    assign imm_bad = !imm_fits(req_kind, req_imm);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            err <= 1'b0;
        else if (state == ST_IDLE && start)
            err <= 1'b0;
        else if (accept && imm_bad)
            err <= 1'b1;
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encoding table, stalls, drain, address wrap, reset.
module tb_instr_encoder;
    import encoder_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        stop;
    logic [31:0] base_addr;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_kind;
    logic [3:0]  req_alu;
    logic [4:0]  req_rd;
    logic [4:0]  req_rs1;
    logic [4:0]  req_rs2;
    logic [31:0] req_imm;
    logic        mem_we;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [15:0] count;
    logic        busy;
    logic        done;
    logic        err;

`ifdef ENC_IMM_CHECK_EN
    localparam logic imm_chk = 1'b1;
`else
    localparam logic imm_chk = 1'b0;
`endif

    typedef struct {
        logic [2:0]  kind;
        logic [3:0]  alu;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] exp;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs [NVEC];
    vec_t v_big;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q [$];
    logic [63:0] mon_exp;
    logic [31:0] exp_addr;
    logic [15:0] exp_cnt;

    instr_encoder dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .stop      (stop),
        .base_addr (base_addr),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_kind  (req_kind),
        .req_alu   (req_alu),
        .req_rd    (req_rd),
        .req_rs1   (req_rs1),
        .req_rs2   (req_rs2),
        .req_imm   (req_imm),
        .mem_we    (mem_we),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    // Clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    // Scoreboard: every completed write must match the head of exp_q.
    always @(posedge clk) begin
        if (mem_we && mem_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h, required no write",
                         mem_addr, mem_wdata);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({mem_addr, mem_wdata} !== mon_exp) begin
                    errors++;
                    $display("FAIL write: got addr 0x%08h data 0x%08h, required addr 0x%08h data 0x%08h",
                             mem_addr, mem_wdata, mon_exp[63:32], mon_exp[31:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
        end
    endtask

    task automatic set_req(input vec_t v);
        req_kind = v.kind;
        req_alu  = v.alu;
        req_rd   = v.rd;
        req_rs1  = v.rs1;
        req_rs2  = v.rs2;
        req_imm  = v.imm;
    endtask

    // One request with mem_ready=1: accept, check the registered word, let it drain.
    task automatic send(input vec_t v, input string name);
        set_req(v);
        req_valid = 1'b1;
        mem_ready = 1'b1;
        check({name, "_ready"}, 64'(req_ready), 64'(1));
        exp_q.push_back({exp_addr, v.exp});
        tick();
        req_valid = 1'b0;
        check({name, "_we"}, 64'(mem_we), 64'(1));
        check({name, "_word"}, 64'(mem_wdata), 64'(v.exp));
        check({name, "_addr"}, 64'(mem_addr), 64'(exp_addr));
        tick();
        exp_addr = exp_addr + 32'd4;
        exp_cnt  = exp_cnt + 16'd1;
        check({name, "_idle_we"}, 64'(mem_we), 64'(0));
    endtask

    task automatic do_start(input logic [31:0] base, input logic with_stop);
        base_addr = base;
        start     = 1'b1;
        stop      = with_stop;
        tick();
        start     = 1'b0;
        stop      = 1'b0;
        exp_addr  = {base[31:2], 2'b00};
        exp_cnt   = 16'h0;
        check("start_busy", 64'(busy), 64'(1));
        check("start_addr", 64'(mem_addr), 64'(exp_addr));
        check("start_count", 64'(count), 64'(0));
        check("start_err", 64'(err), 64'(0));
    endtask

    initial begin
        int done_pulses;
        int waited;

        vecs[0]  = '{KIND_R,      ALU_ADD, 5'd1, 5'd2, 5'd3, 32'd0,        32'h003100B3};
        vecs[1]  = '{KIND_R,      ALU_SUB, 5'd1, 5'd2, 5'd3, 32'd0,        32'h403100B3};
        vecs[2]  = '{KIND_R,      ALU_AND, 5'd4, 5'd5, 5'd6, 32'd0,        32'h0062F233};
        vecs[3]  = '{KIND_R,      ALU_SLT, 5'd1, 5'd1, 5'd1, 32'd0,        32'h0010A0B3};
        vecs[4]  = '{KIND_R,      4'b1111, 5'd1, 5'd2, 5'd3, 32'd0,        32'h003100B3};
        vecs[5]  = '{KIND_I_ALU,  ALU_ADD, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF, 32'hFFF00093};
        vecs[6]  = '{KIND_I_ALU,  ALU_SUB, 5'd1, 5'd0, 5'd9, 32'd5,        32'h00500093};
        vecs[7]  = '{KIND_I_ALU,  ALU_SRA, 5'd5, 5'd6, 5'd0, 32'd3,        32'h40335293};
        vecs[8]  = '{KIND_I_ALU,  ALU_SLL, 5'd1, 5'd1, 5'd0, 32'h25,       32'h00509093};
        vecs[9]  = '{KIND_LOAD,   ALU_ADD, 5'd2, 5'd3, 5'd7, 32'd8,        32'h0081A103};
        vecs[10] = '{KIND_STORE,  ALU_ADD, 5'd7, 5'd3, 5'd2, 32'd8,        32'h0021A423};
        vecs[11] = '{KIND_BRANCH, ALU_ADD, 5'd9, 5'd1, 5'd2, 32'hFFFFFFF8, 32'hFE208CE3};
        vecs[12] = '{KIND_JAL,    ALU_ADD, 5'd1, 5'd5, 5'd0, 32'd2048,     32'h001000EF};
        vecs[13] = '{KIND_JAL,    ALU_ADD, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC, 32'hFFDFF06F};
        v_big    = '{KIND_I_ALU,  ALU_ADD, 5'd1, 5'd0, 5'd0, 32'd2048,     32'h80000093};

        // Reset state
        reset_n   = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        base_addr = 32'h0;
        req_valid = 1'b0;
        mem_ready = 1'b0;
        set_req(vecs[0]);
        exp_addr  = 32'h0;
        exp_cnt   = 16'h0;
        #1;
        check("rst_we", 64'(mem_we), 64'(0));
        check("rst_addr", 64'(mem_addr), 64'(0));
        check("rst_wdata", 64'(mem_wdata), 64'(0));
        check("rst_count", 64'(count), 64'(0));
        check("rst_ready", 64'(req_ready), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_err", 64'(err), 64'(0));
        tick();
        tick();
        reset_n = 1'b1;

        // IDLE must refuse requests and stay silent
        req_valid = 1'b1;
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_ready", 64'(req_ready), 64'(0));
            check("idle_we", 64'(mem_we), 64'(0));
        end
        req_valid = 1'b0;

        // Encoding table, base address low bits dropped
        do_start(32'h0000_1003, 1'b0);
        for (int i = 0; i < NVEC; i++)
            send(vecs[i], $sformatf("vec%0d", i));
        check("table_count", 64'(count), 64'(exp_cnt));

        // Stall: word held for three cycles with req_ready low, then written once
        mem_ready = 1'b0;
        set_req(vecs[7]);
        req_valid = 1'b1;
        exp_q.push_back({exp_addr, vecs[7].exp});
        tick();
        set_req(vecs[0]);
        for (int i = 0; i < 3; i++) begin
            check("stall_we", 64'(mem_we), 64'(1));
            check("stall_word", 64'(mem_wdata), 64'(32'h40335293));
            check("stall_addr", 64'(mem_addr), 64'(exp_addr));
            check("stall_ready", 64'(req_ready), 64'(0));
            tick();
        end
        req_valid = 1'b0;
        mem_ready = 1'b1;
        tick();
        exp_addr = exp_addr + 32'd4;
        exp_cnt  = exp_cnt + 16'd1;
        check("stall_after_we", 64'(mem_we), 64'(0));
        check("stall_count", 64'(count), 64'(exp_cnt));

        // Immediate out of range: flag (when enabled), word still written truncated
        send(v_big, "big_imm");
        check("err_set", 64'(err), 64'(imm_chk));
        send(vecs[5], "after_big");
        check("err_sticky", 64'(err), 64'(imm_chk));

        // Stop while stalled: drain, single done pulse, busy drops after
        mem_ready = 1'b0;
        set_req(vecs[0]);
        req_valid = 1'b1;
        exp_q.push_back({exp_addr, vecs[0].exp});
        tick();
        req_valid = 1'b0;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("drain_busy", 64'(busy), 64'(1));
            check("drain_done", 64'(done), 64'(0));
            check("drain_we", 64'(mem_we), 64'(1));
            check("drain_ready", 64'(req_ready), 64'(0));
            tick();
        end
        mem_ready = 1'b1;
        waited = 0;
        while (!done && waited < 8) begin
            tick();
            waited++;
        end
        check("drain_done_seen", 64'(done), 64'(1));
        check("drain_done_busy", 64'(busy), 64'(1));
        exp_addr = exp_addr + 32'd4;
        done_pulses = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done) done_pulses++;
            if (i == 0) check("fin_busy_drop", 64'(busy), 64'(0));
        end
        check("done_pulses", 64'(done_pulses), 64'(0));
        check("idle_err_sticky", 64'(err), 64'(imm_chk));
        check("idle_no_write", 64'(mem_we), 64'(0));

        // Start beats simultaneous stop; address wraps; back-to-back writes
        do_start(32'hFFFF_FFFC, 1'b1);
        mem_ready = 1'b1;
        set_req(vecs[2]);
        req_valid = 1'b1;
        exp_q.push_back({32'hFFFF_FFFC, vecs[2].exp});
        tick();
        check("wrap_first_addr", 64'(mem_addr), 64'(32'hFFFF_FFFC));
        set_req(vecs[3]);
        exp_q.push_back({32'h0000_0000, vecs[3].exp});
        check("b2b_ready", 64'(req_ready), 64'(1));
        tick();
        req_valid = 1'b0;
        check("wrap_addr", 64'(mem_addr), 64'(0));
        check("b2b_word", 64'(mem_wdata), 64'(vecs[3].exp));
        check("b2b_we", 64'(mem_we), 64'(1));
        tick();
        check("wrap_count", 64'(count), 64'(2));
        check("wrap_next_addr", 64'(mem_addr), 64'(4));
        check("wrap_we_low", 64'(mem_we), 64'(0));

        // Reset during a stalled write discards the word; no write until a new start
        mem_ready = 1'b0;
        set_req(vecs[1]);
        req_valid = 1'b1;
        tick();
        check("pre_rst_we", 64'(mem_we), 64'(1));
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_we", 64'(mem_we), 64'(0));
        check("arst_wdata", 64'(mem_wdata), 64'(0));
        check("arst_addr", 64'(mem_addr), 64'(0));
        check("arst_busy", 64'(busy), 64'(0));
        tick();
        reset_n   = 1'b1;
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_rst_ready", 64'(req_ready), 64'(0));
            check("post_rst_we", 64'(mem_we), 64'(0));
        end
        req_valid = 1'b0;
        tick();

        check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
